fifo_rate_ctrl: RTL and testbench

- Single-clock traffic scheduler that sequences one FIFO's write and read ports at runtime-programmable rates.
- Replaces free-running divided write/read clocks with enable strobes derived from `clk`. Each strobe is gated by FIFO full/empty flags.
- Runs a burst of N writes and N reads, checks read data against the written incrementing pattern, and reports done/error.
- Sits between the control/config logic and the FIFO under test.

---
 rtl/fifo_rate_pkg.sv | 23 ++
 rtl/rate_tick_gen.sv | 33 +++
 rtl/fifo_rate_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_rate_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rate_pkg.sv
`default_nettype none
// fifo_rate_pkg: shared state encoding, default widths and request-flag helper
// for the FIFO rate controller.
package fifo_rate_pkg;

  localparam int DEF_CNT_W  = 3;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A tick always (re)arms the request; otherwise it survives until a strobe consumes it.
  function automatic logic req_next(input logic req, input logic tick, input logic strobe);
    return tick | (req & ~strobe);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rate_tick_gen.sv
`default_nettype none
// rate_tick_gen: counts 0..div while enabled and fires a tick on the terminal count.
// Holding enable low parks the counter at zero.
module rate_tick_gen
  import fifo_rate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || (count == div)) begin
      count <= '0;
    end else begin
      count <= count + CNT_ONE;
    end
  end

  assign tick = enable && (count == div);

endmodule
`default_nettype wire

// File: rtl/fifo_rate_ctrl.sv
`default_nettype none
// fifo_rate_ctrl: drives one FIFO's write/read strobes at programmable rates for a
// burst of N words and checks the read-back incrementing pattern.
module fifo_rate_ctrl
  import fifo_rate_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  rd_div,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_rd_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [LEN_W-1:0]  wr_count,
  output logic [LEN_W-1:0]  rd_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [CNT_W-1:0]   wr_div_q;
  logic [CNT_W-1:0]   rd_div_q;
  logic [LEN_W-1:0]   len_q;
  logic               wr_req;
  logic               rd_req;
  logic               chk_pend;
  logic [DATA_W-1:0]  exp_data;

  logic               run;
  logic               flush;
  logic               wr_tick;
  logic               rd_tick;
  logic               rd_en_run;
  logic               last_read;

  assign run   = (state == ST_RUN);
  assign flush = (state == ST_FLUSH);

  rate_tick_gen #(.CNT_W(CNT_W)) u_wr_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (run),
    .div     (wr_div_q),
    .tick    (wr_tick)
  );

  rate_tick_gen #(.CNT_W(CNT_W)) u_rd_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (run),
    .div     (rd_div_q),
    .tick    (rd_tick)
  );

  assign fifo_wr_en   = run && wr_req && !fifo_full && (wr_count < len_q);
  assign rd_en_run    = run && rd_req && !fifo_empty && (rd_count < len_q);
  assign fifo_rd_en   = rd_en_run || (flush && !fifo_empty);
  assign fifo_wr_data = wr_count[DATA_W-1:0];
  assign busy         = run || flush;

  // The final read moves straight to DONE so its data check lands in DONE.
  assign last_read    = rd_en_run && (rd_count == (len_q - LEN_ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wr_div_q <= '0;
      rd_div_q <= '0;
      len_q    <= '0;
      wr_req   <= 1'b0;
      rd_req   <= 1'b0;
      chk_pend <= 1'b0;
      exp_data <= '0;
      wr_count <= '0;
      rd_count <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;

      if (run) begin
        wr_req <= req_next(wr_req, wr_tick, fifo_wr_en);
        rd_req <= req_next(rd_req, rd_tick, rd_en_run);
      end else begin
        wr_req <= 1'b0;
        rd_req <= 1'b0;
      end

      if (fifo_wr_en) begin
        wr_count <= wr_count + LEN_ONE;
      end
      if (fifo_rd_en) begin
        rd_count <= rd_count + LEN_ONE;
        exp_data <= rd_count[DATA_W-1:0];
      end

      // Only words read during RUN are checked; flushed data is discarded.
      chk_pend <= rd_en_run;
      if (chk_pend && !flush && (fifo_rd_data != exp_data)) begin
        err <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            wr_div_q <= wr_div;
            rd_div_q <= rd_div;
            len_q    <= burst_len;
            wr_count <= '0;
            rd_count <= '0;
            err      <= 1'b0;
            aborted  <= 1'b0;
            state    <= (burst_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_read) begin
            state <= ST_DONE;
          end else if (abort) begin
            state   <= ST_FLUSH;
            aborted <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rate_ctrl.sv
`default_nettype none
// tb_fifo_rate_ctrl: drives bursts against a behavioural FIFO and scores the
// controller's strobes, counters and status flags.
module tb_fifo_rate_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] wr_div = 3'd0;
  logic [2:0] rd_div = 3'd0;
  logic [7:0] burst_len = 8'd0;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_en;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;
  logic [7:0] wr_count;
  logic [7:0] rd_count;

  fifo_rate_ctrl #(.CNT_W(3), .LEN_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .wr_div       (wr_div),
    .rd_div       (rd_div),
    .burst_len    (burst_len),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .err          (err),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 16-deep FIFO with a one-cycle read latency.
  logic [7:0] mem [0:15];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  logic [7:0] rd_q;
  bit         force_full = 1'b0;
  int         corrupt_val = -1;

  always @(posedge clk) begin
    if (!reset_n) begin
      wp   <= 4'd0;
      rp   <= 4'd0;
      fcnt <= 5'd0;
      rd_q <= 8'd0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp] <= fifo_wr_data;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_en) begin
        rd_q <= (corrupt_val >= 0 && 32'(mem[rp]) == corrupt_val) ? 8'h55 : mem[rp];
        rp   <= rp + 4'd1;
      end
      fcnt <= fcnt + 5'(fifo_wr_en) - 5'(fifo_rd_en);
    end
  end

  assign fifo_empty   = (fcnt == 5'd0);
  assign fifo_full    = force_full || (fcnt == 5'd16);
  assign fifo_rd_data = rd_q;

  // Monitor: records strobe cycles, written data and the first err rise per burst.
  int         clr_id = 0;
  int         seen_id = 0;
  int         wr_cycles[$];
  int         rd_cycles[$];
  logic [7:0] wr_vals[$];
  int         err_rise = -1;
  logic       err_prev = 1'b0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (clr_id != seen_id) begin
      seen_id = clr_id;
      wr_cycles.delete();
      rd_cycles.delete();
      wr_vals.delete();
      err_rise = -1;
    end
    if (reset_n) begin
      if (fifo_wr_en) begin
        wr_cycles.push_back(cyc);
        wr_vals.push_back(fifo_wr_data);
      end
      if (fifo_rd_en) rd_cycles.push_back(cyc);
      if (err && !err_prev && err_rise < 0) err_rise = cyc;
      if (done) done_cnt++;
    end
    err_prev = err;
  end

  // Scoreboard state, owned by the stimulus process.
  typedef struct {
    int wr;
    int rd;
    bit err;
    bit ab;
  } res_t;

  res_t       res_q[$];
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives start in one cycle; returns the RUN-entry cycle. Expected data/results are queued here.
  task automatic launch(input int wd, input int rdv, input int len, input bit ab, input bit ffull,
                        input int e_wr, input int e_rd, input bit e_err, input bit e_ab,
                        output int s);
    res_t r;
    @(posedge clk); #2;
    wr_div     = 3'(wd);
    rd_div     = 3'(rdv);
    burst_len  = 8'(len);
    start      = 1'b1;
    abort      = ab;
    force_full = ffull;
    clr_id++;
    for (int i = 0; i < len; i++) exp_q.push_back(8'(i));
    r.wr = e_wr; r.rd = e_rd; r.err = e_err; r.ab = e_ab;
    res_q.push_back(r);
    s = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic finish_burst(input string tag, output int done_cyc);
    res_t r;
    bit   ok = 1'b0;
    done_cyc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check({tag, "_wr_count"}, 32'(wr_count), 32'(r.wr));
      check({tag, "_rd_count"}, 32'(rd_count), 32'(r.rd));
      check({tag, "_err"},      32'(err),      32'(r.err));
      check({tag, "_aborted"},  32'(aborted),  32'(r.ab));
      check({tag, "_n_writes"}, 32'(wr_vals.size()), 32'(r.wr));
    end else begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end
    foreach (wr_vals[i]) begin
      if (exp_q.size() > 0) check({tag, "_wr_data"}, 32'(wr_vals[i]), 32'(exp_q.pop_front()));
      else                  check({tag, "_wr_data_extra"}, 32'(wr_vals[i]), 32'hFFFF_FFFF);
    end
    exp_q.delete();
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    int s;
    int dc;
    int dcnt0;
    bit hit;
    res_t dummy;

    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_done",     32'(done),       32'd0);
    check("rst_err",      32'(err),        32'd0);
    check("rst_aborted",  32'(aborted),    32'd0);
    check("rst_wr_count", 32'(wr_count),   32'd0);
    check("rst_rd_count", 32'(rd_count),   32'd0);
    check("rst_wr_en",    32'(fifo_wr_en), 32'd0);
    check("rst_rd_en",    32'(fifo_rd_en), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic rates: a write every two cycles, first one two cycles after RUN entry.
    launch(1, 2, 4, 1'b0, 1'b0, 4, 4, 1'b0, 1'b0, s);
    check("basic_busy", 32'(busy), 32'd1);
    finish_burst("basic", dc);
    if (wr_cycles.size() > 0) check("basic_first_wr", 32'(wr_cycles[0]), 32'(s + 2));
    else                      check("basic_first_wr_missing", 32'd0, 32'd1);
    for (int i = 1; i < wr_cycles.size(); i++)
      check("basic_wr_gap", 32'(wr_cycles[i] - wr_cycles[i-1]), 32'd2);

    // Backpressure: full held for RUN cycles 0..4 across the first pending write.
    launch(3, 0, 2, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0, s);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_stall_wr_count", 32'(wr_count),   32'd0);
    check("bp_stall_wr_en",    32'(fifo_wr_en), 32'd0);
    @(posedge clk); #2;
    force_full = 1'b0;
    finish_burst("bp", dc);
    if (wr_cycles.size() == 2) begin
      check("bp_first_wr",  32'(wr_cycles[0]), 32'(s + 5));
      check("bp_second_wr", 32'(wr_cycles[1]), 32'(s + 8));
    end else begin
      check("bp_wr_cycles_size", 32'(wr_cycles.size()), 32'd2);
    end

    // Data error on word 2: err rises two cycles after that word's read strobe.
    corrupt_val = 2;
    launch(0, 0, 4, 1'b0, 1'b0, 4, 4, 1'b1, 1'b0, s);
    finish_burst("derr", dc);
    if (rd_cycles.size() >= 3) check("derr_err_rise", 32'(err_rise), 32'(rd_cycles[2] + 2));
    else                       check("derr_rd_cycles_size", 32'(rd_cycles.size()), 32'd3);

    // Abort after 3 writes / 1 read; flushed word 2 is corrupted but must not set err.
    launch(1, 5, 10, 1'b0, 1'b0, 3, 3, 1'b0, 1'b1, s);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (wr_count == 8'd3 && rd_count == 8'd1) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("abort_point_reached", 32'(hit), 32'd1);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    finish_burst("abort", dc);
    if (rd_cycles.size() == 3) check("abort_flush_gap", 32'(rd_cycles[2] - rd_cycles[1]), 32'd1);
    else                       check("abort_rd_cycles_size", 32'(rd_cycles.size()), 32'd3);
    corrupt_val = -1;

    // Zero-length burst: DONE at RUN-entry cycle, done pulse the cycle after, no strobes.
    launch(2, 2, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, s);
    finish_burst("zero", dc);
    check("zero_done_cycle", 32'(dc), 32'(s + 1));
    check("zero_no_reads",   32'(rd_cycles.size()), 32'd0);

    // start together with abort in IDLE behaves as a plain start.
    launch(0, 0, 2, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0, s);
    finish_burst("start_abort", dc);

    // Abort in the same cycle as the final read: completion wins.
    launch(0, 0, 3, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, s);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (fifo_rd_en && rd_count == 8'd2) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("final_read_reached", 32'(hit), 32'd1);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    finish_burst("abort_last", dc);

    // Asynchronous reset in the middle of a burst.
    launch(0, 1, 10, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, s);
    dummy = res_q.pop_back();
    exp_q.delete();
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    dcnt0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_busy",     32'(busy),       32'd0);
    check("mid_wr_count", 32'(wr_count),   32'd0);
    check("mid_rd_count", 32'(rd_count),   32'd0);
    check("mid_wr_en",    32'(fifo_wr_en), 32'd0);
    check("mid_rd_en",    32'(fifo_rd_en), 32'd0);
    check("mid_done",     32'(done),       32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_done_pulse", 32'(done_cnt), 32'(dcnt0));
    check("mid_idle_busy",     32'(busy),     32'd0);

    launch(0, 0, 3, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, s);
    finish_burst("post_reset", dc);

    check("sb_empty", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
